// File: rtl/audio_voice_mixer.sv
// audio_voice_mixer
// Playback and mixing stage feeding Audio_Controller. A clock-enable divider produces the
// sample-rate tick. A looping background ROM and a one-shot click ROM are sequenced from
// that tick. The active voice is scaled and saturating-added to the codec input samples.
// Everything runs in the single CLOCK_50 domain with a synchronous, active-high reset.
//
// Ports:
//   CLOCK_50            system clock
//   reset               synchronous, active-high reset
//   click_trig          asynchronous button level; a rising edge starts or restarts the click
//   loop_en             enables background playback and its address advance
//   loop_addr/data      background ROM address / data (1-cycle ROM latency)
//   click_addr/data     click ROM address / data (1-cycle ROM latency)
//   audio_in_available  Audio_Controller has an input sample
//   audio_out_allowed   Audio_Controller can accept an output sample
//   left_in/right_in    codec input samples
//   read_audio_in       one-cycle pop pulse
//   write_audio_out     one-cycle push pulse
//   left_out/right_out  registered mixed samples
//   click_active        high while the click is playing
//   sample_tick         one-cycle sample-rate strobe
module audio_voice_mixer #(
    parameter int unsigned TICK_DIV    = 16667,
    parameter int unsigned LOOP_LEN    = 30094,
    parameter int unsigned CLICK_START = 1000,
    parameter int unsigned CLICK_END   = 2613,
    parameter int unsigned SHIFT       = 14
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        click_trig,
    input  logic        loop_en,
    output logic [14:0] loop_addr,
    input  logic [15:0] loop_data,
    output logic [11:0] click_addr,
    input  logic [15:0] click_data,
    input  logic        audio_in_available,
    input  logic        audio_out_allowed,
    input  logic [31:0] left_in,
    input  logic [31:0] right_in,
    output logic        read_audio_in,
    output logic        write_audio_out,
    output logic [31:0] left_out,
    output logic [31:0] right_out,
    output logic        click_active,
    output logic        sample_tick
);

    localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // ---------------- Sample tick ----------------
    logic [TickW-1:0] r_tick_cnt;
    logic             w_tick;

    assign w_tick      = (r_tick_cnt == TickW'(TICK_DIV - 1));
    assign sample_tick = w_tick;

    always_ff @(posedge CLOCK_50) begin
        if (reset || w_tick) r_tick_cnt <= '0;
        else                 r_tick_cnt <= r_tick_cnt + TickW'(1);
    end

    // ---------------- Loop voice address ----------------
    logic [14:0] r_loop_addr;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_loop_addr <= '0;
        end else if (w_tick && loop_en) begin
            if (r_loop_addr == 15'(LOOP_LEN - 1)) r_loop_addr <= '0;
            else                                  r_loop_addr <= r_loop_addr + 15'd1;
        end
    end

    assign loop_addr = r_loop_addr;

    // ---------------- Click trigger synchronizer ----------------
    logic r_trig_sync_q;
    logic r_trig_sync_qq;
    logic w_rise;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_trig_sync_q  <= 1'b0;
            r_trig_sync_qq <= 1'b0;
        end else begin
            r_trig_sync_q  <= click_trig;
            r_trig_sync_qq <= r_trig_sync_q;
        end
    end

    assign w_rise = r_trig_sync_q & ~r_trig_sync_qq;

    // ---------------- Click FSM ----------------
    typedef enum logic {ClkIdle, ClkPlay} click_state_e;

    click_state_e r_click_state;
    click_state_e w_click_state_d;
    logic [11:0]  r_click_addr;
    logic [11:0]  w_click_addr_d;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_click_state <= ClkIdle;
            r_click_addr  <= '0;
        end else begin
            r_click_state <= w_click_state_d;
            r_click_addr  <= w_click_addr_d;
        end
    end

    // A rise takes priority over a coincident tick, so a restart always lands on CLICK_START.
    always_comb begin
        w_click_state_d = r_click_state;
        w_click_addr_d  = r_click_addr;
        if (w_rise) begin
            w_click_state_d = ClkPlay;
            w_click_addr_d  = 12'(CLICK_START);
        end else if (r_click_state == ClkPlay && w_tick) begin
            if (r_click_addr == 12'(CLICK_END - 1)) begin
                w_click_state_d = ClkIdle;
                w_click_addr_d  = '0;
            end else begin
                w_click_addr_d  = r_click_addr + 12'd1;
            end
        end
    end

    always_comb begin
        click_active = (r_click_state == ClkPlay);
        click_addr   = r_click_addr;
    end

    // ---------------- Voice select ----------------
    // Both selects are delayed one cycle to line up with the registered ROM outputs.
    logic        r_sel_q;
    logic        r_loop_en_q;
    logic [15:0] w_voice;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_sel_q     <= 1'b0;
            r_loop_en_q <= 1'b0;
        end else begin
            r_sel_q     <= click_active;
            r_loop_en_q <= loop_en;
        end
    end

    assign w_voice = r_sel_q ? click_data : (r_loop_en_q ? loop_data : 16'd0);

    // ---------------- Mix arithmetic ----------------
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {a[31], a} + {b[31], b};
        // Sign bits disagree only when the 32-bit result overflowed.
        if (sum[32] != sum[31]) return sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return sum[31:0];
    endfunction

    logic [31:0] r_left_lat;
    logic [31:0] r_right_lat;
    logic [15:0] r_voice_lat;
    logic [31:0] w_scaled;

    assign w_scaled = {{16{r_voice_lat[15]}}, r_voice_lat} << SHIFT;

    // ---------------- Handshake FSM ----------------
    typedef enum logic [1:0] {HWait, HMix, HWrite} hs_state_e;

    hs_state_e   r_hs_state;
    hs_state_e   w_hs_state_d;
    logic        w_latch;
    logic        w_write_d;
    logic        r_write;
    logic [31:0] r_left_out;
    logic [31:0] r_right_out;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_hs_state  <= HWait;
            r_left_lat  <= '0;
            r_right_lat <= '0;
            r_voice_lat <= '0;
            r_left_out  <= '0;
            r_right_out <= '0;
            r_write     <= 1'b0;
        end else begin
            r_hs_state <= w_hs_state_d;
            r_write    <= w_write_d;
            if (w_latch) begin
                r_left_lat  <= left_in;
                r_right_lat <= right_in;
                r_voice_lat <= w_voice;
            end
            if (r_hs_state == HMix) begin
                r_left_out  <= sat_add(r_left_lat, w_scaled);
                r_right_out <= sat_add(r_right_lat, w_scaled);
            end
        end
    end

    always_comb begin
        w_hs_state_d = r_hs_state;
        w_latch      = 1'b0;
        w_write_d    = 1'b0;
        unique case (r_hs_state)
            HWait: begin
                if (audio_in_available && audio_out_allowed) begin
                    w_latch      = 1'b1;
                    w_hs_state_d = HMix;
                end
            end
            HMix: w_hs_state_d = HWrite;
            HWrite: begin
                if (audio_out_allowed) begin
                    w_write_d    = 1'b1;
                    w_hs_state_d = HWait;
                end
            end
            default: w_hs_state_d = HWait;
        endcase
    end

    // The pop pulse is the single cycle spent in HMix, right after the samples were latched.
    always_comb begin
        read_audio_in   = (r_hs_state == HMix);
        write_audio_out = r_write;
        left_out        = r_left_out;
        right_out       = r_right_out;
    end

endmodule

// File: tb/tb_audio_voice_mixer.sv
// tb_audio_voice_mixer
// Directed bench for audio_voice_mixer with a shortened tick period and loop length so
// every sequence fits in a short run. Expected values are hand-computed constants.
module tb_audio_voice_mixer;

    localparam int unsigned TickDiv    = 8;
    localparam int unsigned LoopLen    = 40;
    localparam int unsigned ClickStart = 1000;
    localparam int unsigned ClickEnd   = 2613;
    localparam int unsigned Shift      = 14;

    logic        CLOCK_50;
    logic        reset;
    logic        click_trig;
    logic        loop_en;
    logic [14:0] loop_addr;
    logic [15:0] loop_data;
    logic [11:0] click_addr;
    logic [15:0] click_data;
    logic        audio_in_available;
    logic        audio_out_allowed;
    logic [31:0] left_in;
    logic [31:0] right_in;
    logic        read_audio_in;
    logic        write_audio_out;
    logic [31:0] left_out;
    logic [31:0] right_out;
    logic        click_active;
    logic        sample_tick;

    int n_checks = 0;
    int n_errors = 0;

    audio_voice_mixer #(
        .TICK_DIV   (TickDiv),
        .LOOP_LEN   (LoopLen),
        .CLICK_START(ClickStart),
        .CLICK_END  (ClickEnd),
        .SHIFT      (Shift)
    ) u_dut (
        .CLOCK_50          (CLOCK_50),
        .reset             (reset),
        .click_trig        (click_trig),
        .loop_en           (loop_en),
        .loop_addr         (loop_addr),
        .loop_data         (loop_data),
        .click_addr        (click_addr),
        .click_data        (click_data),
        .audio_in_available(audio_in_available),
        .audio_out_allowed (audio_out_allowed),
        .left_in           (left_in),
        .right_in          (right_in),
        .read_audio_in     (read_audio_in),
        .write_audio_out   (write_audio_out),
        .left_out          (left_out),
        .right_out         (right_out),
        .click_active      (click_active),
        .sample_tick       (sample_tick)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance one rising edge and sample just after it.
    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Run until a sample_tick is seen, then take the edge that consumes it.
    task automatic do_tick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < int'(TickDiv) + 2; i++) begin
            if (sample_tick) begin
                seen = 1'b1;
                step();
                break;
            end
            step();
        end
        if (!seen) check_val("tick_timeout", 32'd0, 32'd1);
    endtask

    // One full handshake; audio_out_allowed is held low for 'stall' cycles in the write state.
    task automatic xfer(input string tag, input logic [31:0] l, input logic [31:0] r,
                        input logic [31:0] exp_l, input logic [31:0] exp_r, input int stall);
        left_in            = l;
        right_in           = r;
        audio_in_available = 1'b1;
        audio_out_allowed  = 1'b1;
        step();
        check_val({tag, "_read"}, 32'(read_audio_in), 32'd1);
        audio_in_available = 1'b0;
        if (stall > 0) audio_out_allowed = 1'b0;
        step();
        check_val({tag, "_read_once"}, 32'(read_audio_in), 32'd0);
        check_val({tag, "_left_mix"}, left_out, exp_l);
        check_val({tag, "_no_write_yet"}, 32'(write_audio_out), 32'd0);
        for (int i = 0; i < stall; i++) begin
            step();
            check_val({tag, "_stall_write"}, 32'(write_audio_out), 32'd0);
            check_val({tag, "_stall_hold"}, left_out, exp_l);
        end
        audio_out_allowed = 1'b1;
        step();
        check_val({tag, "_write"}, 32'(write_audio_out), 32'd1);
        check_val({tag, "_left"}, left_out, exp_l);
        check_val({tag, "_right"}, right_out, exp_r);
        step();
        check_val({tag, "_write_once"}, 32'(write_audio_out), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset              = 1'b1;
        click_trig         = 1'b0;
        loop_en            = 1'b0;
        loop_data          = 16'h0000;
        click_data         = 16'h0000;
        audio_in_available = 1'b0;
        audio_out_allowed  = 1'b0;
        left_in            = 32'h0;
        right_in           = 32'h0;
        step_n(3);

        // Reset state
        check_val("rst_loop_addr", 32'(loop_addr), 32'd0);
        check_val("rst_click_addr", 32'(click_addr), 32'd0);
        check_val("rst_click_active", 32'(click_active), 32'd0);
        check_val("rst_tick", 32'(sample_tick), 32'd0);
        check_val("rst_read", 32'(read_audio_in), 32'd0);
        check_val("rst_write", 32'(write_audio_out), 32'd0);
        check_val("rst_left", left_out, 32'd0);
        check_val("rst_right", right_out, 32'd0);

        // Tick timing: pulses on cycles TickDiv-1 and 2*TickDiv-1 after release
        reset   = 1'b0;
        loop_en = 1'b1;
        for (int n = 0; n < 2 * int'(TickDiv); n++) begin
            check_val("tick_cycle", 32'(sample_tick),
                      32'((n == int'(TickDiv) - 1) || (n == 2 * int'(TickDiv) - 1)));
            step();
        end
        check_val("loop_addr_2", 32'(loop_addr), 32'd2);
        check_val("idle_click", 32'(click_active), 32'd0);
        check_val("idle_read", 32'(read_audio_in), 32'd0);
        check_val("idle_left", left_out, 32'd0);

        // Loop wrap
        for (int i = 0; i < 37; i++) do_tick();
        check_val("loop_addr_last", 32'(loop_addr), 32'd39);
        do_tick();
        check_val("loop_addr_wrap", 32'(loop_addr), 32'd0);

        // Click start and full run to the end
        click_trig = 1'b1;
        step_n(3);
        check_val("click_start_active", 32'(click_active), 32'd1);
        check_val("click_start_addr", 32'(click_addr), 32'd1000);
        for (int i = 0; i < 1612; i++) do_tick();
        check_val("click_last_addr", 32'(click_addr), 32'd2612);
        check_val("click_last_active", 32'(click_active), 32'd1);
        do_tick();
        check_val("click_end_addr", 32'(click_addr), 32'd0);
        check_val("click_end_active", 32'(click_active), 32'd0);

        // Re-trigger mid-play at 1500
        click_trig = 1'b0;
        step_n(3);
        click_trig = 1'b1;
        step_n(3);
        check_val("click_again_addr", 32'(click_addr), 32'd1000);
        for (int i = 0; i < 500; i++) do_tick();
        check_val("click_1500", 32'(click_addr), 32'd1500);
        click_trig = 1'b0;
        step_n(2);
        click_trig = 1'b1;
        step_n(3);
        check_val("retrig_addr", 32'(click_addr), 32'd1000);

        // Re-trigger whose rise lands on the same cycle as sample_tick
        click_trig = 1'b0;
        step_n(3);
        do_tick();
        step_n(6);
        click_trig = 1'b1;
        step();
        check_val("coinc_tick", 32'(sample_tick), 32'd1);
        step();
        check_val("retrig_coinc_addr", 32'(click_addr), 32'd1000);
        click_trig = 1'b0;

        // Mixing with the click voice selected
        click_data = 16'h0001;
        xfer("mix_small", 32'h0000_0010, 32'h0000_0020, 32'h0000_4010, 32'h0000_4020, 0);
        click_data = 16'h7FFF;
        xfer("sat_pos_stall", 32'h7FFF_F000, 32'h0000_0000, 32'h7FFF_FFFF, 32'h1FFF_C000, 5);
        click_data = 16'hFFFF;
        xfer("neg_one", 32'h0000_0000, 32'h8000_3FFF, 32'hFFFF_C000, 32'h8000_0000, 0);

        // Reset in the middle of a handshake
        left_in            = 32'h0000_0005;
        audio_in_available = 1'b1;
        audio_out_allowed  = 1'b1;
        step();
        reset              = 1'b1;
        audio_in_available = 1'b0;
        step();
        check_val("midrst_read", 32'(read_audio_in), 32'd0);
        check_val("midrst_write", 32'(write_audio_out), 32'd0);
        check_val("midrst_click_active", 32'(click_active), 32'd0);
        check_val("midrst_click_addr", 32'(click_addr), 32'd0);
        check_val("midrst_loop_addr", 32'(loop_addr), 32'd0);
        check_val("midrst_left", left_out, 32'd0);
        check_val("midrst_right", right_out, 32'd0);
        reset = 1'b0;

        // Loop voice selected (click idle), negative saturation
        loop_en   = 1'b1;
        loop_data = 16'h8000;
        step_n(2);
        xfer("sat_neg", 32'h8000_0000, 32'h0000_1234, 32'h8000_0000, 32'hE000_1234, 0);

        // Loop disabled: voice is zero even with ROM data present
        loop_en = 1'b0;
        step_n(2);
        xfer("no_voice", 32'h1234_5678, 32'hFEDC_BA98, 32'h1234_5678, 32'hFEDC_BA98, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
